// File: rtl/ib_bm_initiator.sv
`default_nettype none
// ============================================================================
// Module   : ib_bm_initiator
// Brief    : Tagged bus-master request initiator with busy-tag tracking.
//            Optional REQ-to-ACK watchdog enabled by macro IB_BM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ib_bm_initiator #(
  parameter int MAX_PENDING    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [63:0] CMD_GLOBAL_ADDR,
  input  logic [31:0] CMD_LOCAL_ADDR,
  input  logic [11:0] CMD_LENGTH,
  input  logic [1:0]  CMD_TRANS_TYPE,
  input  logic        CMD_VLD,
  output logic        CMD_RDY,
  output logic [63:0] BM_GLOBAL_ADDR,
  output logic [31:0] BM_LOCAL_ADDR,
  output logic [11:0] BM_LENGTH,
  output logic [1:0]  BM_TRANS_TYPE,
  output logic [15:0] BM_TAG,
  output logic        BM_REQ,
  input  logic        BM_ACK,
  input  logic [15:0] BM_OP_TAG,
  input  logic        BM_OP_DONE,
  output logic [3:0]  DONE_TAG,
  output logic        DONE_VLD,
  output logic [4:0]  PENDING,
  output logic        ERR_SPURIOUS
`ifdef IB_BM_TIMEOUT_EN
  ,
  output logic        ERR_TIMEOUT
`endif
);

  if (MAX_PENDING < 1 || MAX_PENDING > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("ib_bm_initiator: parameter out of range");
  end

  localparam logic [4:0] C_MAX_PEND = 5'(MAX_PENDING);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  next_tag_q, next_tag_d;
  logic [15:0] busy_q, busy_d;
  logic [4:0]  pending_q, pending_d;
  logic [63:0] gaddr_q, gaddr_d;
  logic [31:0] laddr_q, laddr_d;
  logic [11:0] len_q, len_d;
  logic [1:0]  ttype_q, ttype_d;
  logic [3:0]  req_tag_q, req_tag_d;
  logic        done_vld_q, done_vld_d;
  logic [3:0]  done_tag_q, done_tag_d;
  logic        err_spur_q, err_spur_d;

  logic        w_rdy;
  logic        w_accept;
  logic        w_ack;
  logic        w_done_ok;

  always_comb begin
    state_d    = state_q;
    next_tag_d = next_tag_q;
    busy_d     = busy_q;
    pending_d  = pending_q;
    gaddr_d    = gaddr_q;
    laddr_d    = laddr_q;
    len_d      = len_q;
    ttype_d    = ttype_q;
    req_tag_d  = req_tag_q;
    done_tag_d = done_tag_q;

    w_rdy      = (state_q == S_IDLE) && (pending_q < C_MAX_PEND) && !busy_q[next_tag_q];
    w_accept   = CMD_VLD && w_rdy;
    w_ack      = (state_q == S_REQ) && BM_ACK;
    // Completions are judged against the pre-edge bitmap, so a tag issued on
    // this same edge can never be retired by it.
    w_done_ok  = BM_OP_DONE && (BM_OP_TAG[15:4] == 12'd0) && busy_q[BM_OP_TAG[3:0]];
    done_vld_d = w_done_ok;
    err_spur_d = err_spur_q | (BM_OP_DONE && !w_done_ok);

    if (w_done_ok) begin
      busy_d[BM_OP_TAG[3:0]] = 1'b0;
      done_tag_d             = BM_OP_TAG[3:0];
    end

    if (w_ack) begin
      busy_d[req_tag_q] = 1'b1;
      next_tag_d        = next_tag_q + 4'd1;
      state_d           = S_IDLE;
    end

    case ({w_ack, w_done_ok})
      2'b10:   pending_d = pending_q + 5'd1;
      2'b01:   pending_d = pending_q - 5'd1;
      default: pending_d = pending_q;
    endcase

    if (w_accept) begin
      state_d   = S_REQ;
      gaddr_d   = CMD_GLOBAL_ADDR;
      laddr_d   = CMD_LOCAL_ADDR;
      len_d     = CMD_LENGTH;
      ttype_d   = CMD_TRANS_TYPE;
      req_tag_d = next_tag_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      next_tag_q <= 4'd0;
      busy_q     <= 16'd0;
      pending_q  <= 5'd0;
      gaddr_q    <= 64'd0;
      laddr_q    <= 32'd0;
      len_q      <= 12'd0;
      ttype_q    <= 2'd0;
      req_tag_q  <= 4'd0;
      done_vld_q <= 1'b0;
      done_tag_q <= 4'd0;
      err_spur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_tag_q <= next_tag_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      gaddr_q    <= gaddr_d;
      laddr_q    <= laddr_d;
      len_q      <= len_d;
      ttype_q    <= ttype_d;
      req_tag_q  <= req_tag_d;
      done_vld_q <= done_vld_d;
      done_tag_q <= done_tag_d;
      err_spur_q <= err_spur_d;
    end
  end

`ifdef IB_BM_TIMEOUT_EN
  localparam logic [15:0] C_TMO_LIM = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_tmo_q, err_tmo_d;

  // Counter saturates so a limit near the top of the range still trips.
  always_comb begin
    tmo_cnt_d = 16'd0;
    err_tmo_d = err_tmo_q;
    if (state_q == S_REQ) begin
      tmo_cnt_d = (tmo_cnt_q != 16'hFFFF) ? tmo_cnt_q + 16'd1 : tmo_cnt_q;
      if (tmo_cnt_q >= C_TMO_LIM) begin
        err_tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tmo_cnt_q <= 16'd0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign ERR_TIMEOUT = err_tmo_q;
`else
`endif

  assign CMD_RDY        = w_rdy;
  assign BM_REQ         = (state_q == S_REQ);
  assign BM_TAG         = {12'd0, req_tag_q};
  assign BM_GLOBAL_ADDR = gaddr_q;
  assign BM_LOCAL_ADDR  = laddr_q;
  assign BM_LENGTH      = len_q;
  assign BM_TRANS_TYPE  = ttype_q;
  assign PENDING        = pending_q;
  assign DONE_VLD       = done_vld_q;
  assign DONE_TAG       = done_tag_q;
  assign ERR_SPURIOUS   = err_spur_q;

endmodule
`default_nettype wire

// File: tb/tb_ib_bm_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ib_bm_initiator
// Brief    : Directed and randomized checks of ib_bm_initiator against a
//            tag-set reference model.
// Revision : 1.0
// ============================================================================
module tb_ib_bm_initiator;
  localparam int MAXP = 8;
`ifdef IB_BM_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        CLK, RESET;
  logic [63:0] cmd_ga;
  logic [31:0] cmd_la;
  logic [11:0] cmd_len;
  logic [1:0]  cmd_tt;
  logic        cmd_vld, bm_ack, op_done;
  logic [15:0] op_tag;
  logic        CMD_RDY, BM_REQ, DONE_VLD, ERR_SPURIOUS;
  logic [63:0] BM_GLOBAL_ADDR;
  logic [31:0] BM_LOCAL_ADDR;
  logic [11:0] BM_LENGTH;
  logic [1:0]  BM_TRANS_TYPE;
  logic [15:0] BM_TAG;
  logic [3:0]  DONE_TAG;
  logic [4:0]  PENDING;
`ifdef IB_BM_TIMEOUT_EN
  logic        ERR_TIMEOUT;
`endif

  int n_chk = 0;
  int n_pass = 0;

  ib_bm_initiator #(.MAX_PENDING(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_GLOBAL_ADDR(cmd_ga), .CMD_LOCAL_ADDR(cmd_la), .CMD_LENGTH(cmd_len),
    .CMD_TRANS_TYPE(cmd_tt), .CMD_VLD(cmd_vld), .CMD_RDY(CMD_RDY),
    .BM_GLOBAL_ADDR(BM_GLOBAL_ADDR), .BM_LOCAL_ADDR(BM_LOCAL_ADDR),
    .BM_LENGTH(BM_LENGTH), .BM_TRANS_TYPE(BM_TRANS_TYPE), .BM_TAG(BM_TAG),
    .BM_REQ(BM_REQ), .BM_ACK(bm_ack), .BM_OP_TAG(op_tag), .BM_OP_DONE(op_done),
    .DONE_TAG(DONE_TAG), .DONE_VLD(DONE_VLD), .PENDING(PENDING),
    .ERR_SPURIOUS(ERR_SPURIOUS)
`ifdef IB_BM_TIMEOUT_EN
    , .ERR_TIMEOUT(ERR_TIMEOUT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: set of outstanding tags plus the request in flight.
  bit          m_busy [16];
  int          m_next, m_tag, m_dt;
  bit          m_inreq, m_dv, m_spur;
  logic [63:0] m_ga;
  logic [31:0] m_la;
  logic [11:0] m_len;
  logic [1:0]  m_tt;

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit m_rdy();
    return !m_inreq && (m_pending() < MAXP) && !m_busy[m_next];
  endfunction

  task automatic step();
    bit acc, ackv, ok;
    if (!RESET) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_next = 0; m_tag = 0; m_dt = 0;
      m_inreq = 0; m_dv = 0; m_spur = 0;
      m_ga = '0; m_la = '0; m_len = '0; m_tt = '0;
    end else begin
      acc  = cmd_vld && m_rdy();
      ackv = m_inreq && bm_ack;
      ok   = op_done && (op_tag[15:4] == 12'd0) && m_busy[op_tag[3:0]];
      if (op_done && !ok) m_spur = 1'b1;
      m_dv = ok;
      if (ok) begin
        m_dt = int'(op_tag[3:0]);
        m_busy[op_tag[3:0]] = 1'b0;
      end
      if (ackv) begin
        m_busy[m_tag] = 1'b1;
        m_next  = (m_next + 1) % 16;
        m_inreq = 1'b0;
      end
      if (acc) begin
        m_inreq = 1'b1; m_tag = m_next;
        m_ga = cmd_ga; m_la = cmd_la; m_len = cmd_len; m_tt = cmd_tt;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0; cmd_vld = 0; bm_ack = 0; op_done = 0; op_tag = '0;
    step(); step();
    RESET = 1'b1;
  endtask

  task automatic issue(input int dly);
    int i;
    cmd_ga = {$urandom, $urandom}; cmd_la = $urandom;
    cmd_len = 12'($urandom); cmd_tt = 2'($urandom);
    cmd_vld = 1'b1;
    for (i = 0; i < 100 && CMD_RDY !== 1'b1; i++) step();
    if (CMD_RDY !== 1'b1) begin
      n_chk++;
      $display("FAIL issue_wait: CMD_RDY got %b want 1 within 100 cycles", CMD_RDY);
    end
    step();
    cmd_vld = 1'b0;
    repeat (dly) step();
    bm_ack = 1'b1; step(); bm_ack = 1'b0;
  endtask

  task automatic done(input logic [15:0] t);
    op_tag = t; op_done = 1'b1; step(); op_done = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; cmd_vld = 1; bm_ack = 1; op_done = 1; op_tag = 16'h0003;
    step(); step();
    n_chk++;
    if ({BM_REQ, PENDING, DONE_VLD, DONE_TAG, ERR_SPURIOUS, BM_TAG} !== 28'd0)
      $display("FAIL reset_ctl: got %h want 0", {BM_REQ, PENDING, DONE_VLD, DONE_TAG, ERR_SPURIOUS, BM_TAG});
    else n_pass++;
    n_chk++;
    if ({BM_GLOBAL_ADDR, BM_LOCAL_ADDR, BM_LENGTH, BM_TRANS_TYPE} !== 110'd0)
      $display("FAIL reset_data: got %h want 0", {BM_GLOBAL_ADDR, BM_LOCAL_ADDR, BM_LENGTH, BM_TRANS_TYPE});
    else n_pass++;
    n_chk++;
    if (CMD_RDY !== 1'b1) $display("FAIL reset_rdy: got %b want 1", CMD_RDY);
    else n_pass++;
    cmd_vld = 0; bm_ack = 0; op_done = 0;
    RESET = 1'b1;
  endtask

  task automatic test_single();
    int hi = 0;
    do_reset();
    cmd_ga = 64'h1000_0000_0000_0040; cmd_la = 32'h200; cmd_len = 12'd64; cmd_tt = 2'b00;
    cmd_vld = 1'b1; step(); cmd_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (BM_REQ === 1'b1) hi++;
      if (i == 2) bm_ack = 1'b1;
      step();
    end
    bm_ack = 1'b0;
    n_chk++;
    if (hi != 3 || BM_REQ !== 1'b0) $display("FAIL single_req_len: got %0d high, req %b want 3, 0", hi, BM_REQ);
    else n_pass++;
    n_chk++;
    if ({BM_TAG, PENDING} !== {16'd0, 5'd1}) $display("FAIL single_tag_pend: got %h/%0d want 0/1", BM_TAG, PENDING);
    else n_pass++;
    n_chk++;
    if ({BM_GLOBAL_ADDR, BM_LOCAL_ADDR, BM_LENGTH, BM_TRANS_TYPE} !== {64'h1000_0000_0000_0040, 32'h200, 12'd64, 2'b00})
      $display("FAIL single_fields: got %h %h %0d %b", BM_GLOBAL_ADDR, BM_LOCAL_ADDR, BM_LENGTH, BM_TRANS_TYPE);
    else n_pass++;
    done(16'h0000);
    n_chk++;
    if ({DONE_VLD, DONE_TAG, PENDING} !== {1'b1, 4'd0, 5'd0})
      $display("FAIL single_done: got vld %b tag %0d pend %0d want 1 0 0", DONE_VLD, DONE_TAG, PENDING);
    else n_pass++;
    step();
    n_chk++;
    if (DONE_VLD !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", DONE_VLD);
    else n_pass++;
  endtask

  task automatic test_fill();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(0);
      if (BM_TAG !== 16'(i)) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL fill_tags: got %0d wrong tags want 0", bad);
    else n_pass++;
    n_chk++;
    if ({CMD_RDY, PENDING} !== {1'b0, 5'd8}) $display("FAIL fill_full: got rdy %b pend %0d want 0 8", CMD_RDY, PENDING);
    else n_pass++;
    done(16'h0003);
    n_chk++;
    if ({CMD_RDY, PENDING} !== {1'b1, 5'd7}) $display("FAIL fill_free: got rdy %b pend %0d want 1 7", CMD_RDY, PENDING);
    else n_pass++;
    issue(1);
    n_chk++;
    if ({BM_TAG, PENDING, CMD_RDY} !== {16'd8, 5'd8, 1'b0})
      $display("FAIL fill_tag8: got tag %0d pend %0d rdy %b want 8 8 0", BM_TAG, PENDING, CMD_RDY);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int leaks = 0;
    do_reset();
    for (int i = 0; i < 8; i++) issue(0);
    for (int t = 8; t < 16; t++) begin
      done(16'(t - 7));
      issue(0);
    end
    for (int t = 9; t < 16; t++) done(16'(t));
    n_chk++;
    if ({PENDING, CMD_RDY} !== {5'd1, 1'b0}) $display("FAIL wrap_block: got pend %0d rdy %b want 1 0", PENDING, CMD_RDY);
    else n_pass++;
    cmd_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (BM_REQ !== 1'b0 || CMD_RDY !== 1'b0) leaks++;
    end
    cmd_vld = 1'b0;
    n_chk++;
    if (leaks != 0) $display("FAIL wrap_hold: got %0d cycles with req/rdy want 0", leaks);
    else n_pass++;
    done(16'h0000);
    n_chk++;
    if (CMD_RDY !== 1'b1) $display("FAIL wrap_release: got %b want 1", CMD_RDY);
    else n_pass++;
    issue(0);
    n_chk++;
    if ({BM_TAG, PENDING} !== {16'd0, 5'd1}) $display("FAIL wrap_tag0: got tag %0d pend %0d want 0 1", BM_TAG, PENDING);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    do_reset();
    issue(0); issue(2);
    cmd_vld = 1'b1; step(); cmd_vld = 1'b0;
    bm_ack = 1'b1; op_tag = 16'h0000; op_done = 1'b1;
    step();
    bm_ack = 1'b0; op_done = 1'b0;
    n_chk++;
    if ({PENDING, DONE_VLD, DONE_TAG, BM_TAG[3:0], BM_REQ} !== {5'd2, 1'b1, 4'd0, 4'd2, 1'b0})
      $display("FAIL same_edge: got pend %0d vld %b dtag %0d tag %0d req %b want 2 1 0 2 0",
               PENDING, DONE_VLD, DONE_TAG, BM_TAG, BM_REQ);
    else n_pass++;
    n_chk++;
    if (CMD_RDY !== 1'b1) $display("FAIL same_edge_rdy: got %b want 1", CMD_RDY);
    else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset();
    issue(0);
    bm_ack = 1'b1; step(); step(); bm_ack = 1'b0;
    n_chk++;
    if ({PENDING, BM_REQ} !== {5'd1, 1'b0}) $display("FAIL idle_ack: got pend %0d req %b want 1 0", PENDING, BM_REQ);
    else n_pass++;
    done(16'h0005);
    n_chk++;
    if ({ERR_SPURIOUS, PENDING, DONE_VLD} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL spur_tag5: got err %b pend %0d vld %b want 1 1 0", ERR_SPURIOUS, PENDING, DONE_VLD);
    else n_pass++;
    do_reset();
    n_chk++;
    if (ERR_SPURIOUS !== 1'b0) $display("FAIL spur_clear: got %b want 0", ERR_SPURIOUS);
    else n_pass++;
    issue(0);
    done(16'h0010);
    n_chk++;
    if ({ERR_SPURIOUS, PENDING, DONE_VLD} !== {1'b1, 5'd1, 1'b0})
      $display("FAIL spur_hi_bits: got err %b pend %0d vld %b want 1 1 0", ERR_SPURIOUS, PENDING, DONE_VLD);
    else n_pass++;
    done(16'h0000);
    n_chk++;
    if ({ERR_SPURIOUS, PENDING, DONE_VLD} !== {1'b1, 5'd0, 1'b1})
      $display("FAIL spur_sticky: got err %b pend %0d vld %b want 1 0 1", ERR_SPURIOUS, PENDING, DONE_VLD);
    else n_pass++;
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    issue(0);
    cmd_vld = 1'b1; step(); cmd_vld = 1'b0;
    n_chk++;
    if ({BM_REQ, BM_TAG} !== {1'b1, 16'd1}) $display("FAIL mid_pre: got req %b tag %0d want 1 1", BM_REQ, BM_TAG);
    else n_pass++;
    RESET = 1'b0; step(); RESET = 1'b1;
    n_chk++;
    if ({BM_REQ, PENDING, BM_TAG, BM_GLOBAL_ADDR, BM_LOCAL_ADDR, BM_LENGTH, BM_TRANS_TYPE} !== 132'd0)
      $display("FAIL mid_reset: got req %b pend %0d tag %0d ga %h want all 0", BM_REQ, PENDING, BM_TAG, BM_GLOBAL_ADDR);
    else n_pass++;
    done(16'h0000);
    n_chk++;
    if ({ERR_SPURIOUS, DONE_VLD, PENDING} !== {1'b1, 1'b0, 5'd0})
      $display("FAIL mid_stale: got err %b vld %b pend %0d want 1 0 0", ERR_SPURIOUS, DONE_VLD, PENDING);
    else n_pass++;
  endtask

`ifdef IB_BM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cmd_vld = 1'b1; step(); cmd_vld = 1'b0;
    repeat (15) step();
    n_chk++;
    if (ERR_TIMEOUT !== 1'b0) $display("FAIL tmo_early: got %b want 0 after 15 cycles", ERR_TIMEOUT);
    else n_pass++;
    step();
    n_chk++;
    if ({ERR_TIMEOUT, BM_REQ} !== 2'b11) $display("FAIL tmo_set: got err %b req %b want 1 1", ERR_TIMEOUT, BM_REQ);
    else n_pass++;
    RESET = 1'b0; step(); RESET = 1'b1;
    n_chk++;
    if ({ERR_TIMEOUT, BM_REQ, PENDING} !== 7'd0) $display("FAIL tmo_reset: got err %b req %b pend %0d want 0", ERR_TIMEOUT, BM_REQ, PENDING);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int bad = 0;
    int t;
    logic [127:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cmd_ga = {$urandom, $urandom}; cmd_la = $urandom;
      cmd_len = 12'($urandom); cmd_tt = 2'($urandom);
      cmd_vld = ($urandom_range(0, 1) == 1);
      bm_ack  = ($urandom_range(0, 1) == 1);
      op_done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        op_tag = 16'($urandom);
      end else begin
        t = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++)
          if (m_busy[(t + k) % 16]) begin t = (t + k) % 16; break; end
        op_tag = 16'(t);
      end
      step();
      got = {CMD_RDY, BM_REQ, BM_TAG, PENDING, DONE_VLD, DONE_TAG, ERR_SPURIOUS,
             BM_GLOBAL_ADDR, BM_LOCAL_ADDR, BM_LENGTH, BM_TRANS_TYPE};
      exp = {m_rdy(), m_inreq, 16'(m_tag), 5'(m_pending()), m_dv, 4'(m_dt), m_spur,
             m_ga, m_la, m_len, m_tt};
      n_chk++;
      if (got !== exp) begin
        bad++;
        if (bad < 10) $display("FAIL random_cycle%0d: got %h want %h", c, got, exp);
      end else n_pass++;
    end
    cmd_vld = 0; bm_ack = 0; op_done = 0;
  endtask

  initial begin
    RESET = 1'b0; cmd_vld = 0; bm_ack = 0; op_done = 0; op_tag = '0;
    cmd_ga = '0; cmd_la = '0; cmd_len = '0; cmd_tt = '0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_same_edge();
    test_spurious();
    test_reset_mid_req();
`ifdef IB_BM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
